// File: rtl/baccarat_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : baccarat_pkg                                              |
// | Desc   : Shared state encoding, card codes and scoring helpers.    |
// | Rev    : 1.0                                                       |
// +--------------------------------------------------------------------+
package baccarat_pkg;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_P1   = 4'd1,
    S_D1   = 4'd2,
    S_P2   = 4'd3,
    S_D2   = 4'd4,
    S_EVAL = 4'd5,
    S_P3   = 4'd6,
    S_BANK = 4'd7,
    S_D3   = 4'd8,
    S_DONE = 4'd9
  } state_t;

  localparam logic [3:0] CARD_NONE = 4'd0;
  localparam logic [3:0] CARD_A    = 4'd1;
  localparam logic [3:0] CARD_9    = 4'd9;
  localparam logic [3:0] CARD_T    = 4'd10;
  localparam logic [3:0] CARD_J    = 4'd11;
  localparam logic [3:0] CARD_Q    = 4'd12;
  localparam logic [3:0] CARD_K    = 4'd13;

  // Tens, faces, "no card" and any illegal code all score zero.
  function automatic logic [3:0] card_points(input logic [3:0] code);
    if (code >= CARD_A && code <= CARD_9) return code;
    return 4'd0;
  endfunction

  function automatic logic dealer_draws(input logic [3:0] dscore, input logic [3:0] pts);
    case (dscore)
      4'd0, 4'd1, 4'd2: return 1'b1;
      4'd3:             return (pts != 4'd8);
      4'd4:             return (pts >= 4'd2) && (pts <= 4'd7);
      4'd5:             return (pts >= 4'd4) && (pts <= 4'd7);
      4'd6:             return (pts >= 4'd6) && (pts <= 4'd7);
      default:          return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/baccarat_bank_rule.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : baccarat_bank_rule                                        |
// | Desc   : Dealer third-card decision after the player has drawn.    |
// | Rev    : 1.0                                                       |
// +--------------------------------------------------------------------+
module baccarat_bank_rule
  import baccarat_pkg::*;
(
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       draw
);

  logic [3:0] w_pts;

  assign w_pts = card_points(pcard3);
  assign draw  = dealer_draws(dscore, w_pts);

endmodule
`default_nettype wire

// File: rtl/baccarat_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : baccarat_fsm                                              |
// | Desc   : Sequences card load strobes and drives the win lights.    |
// | Rev    : 1.0                                                       |
// +--------------------------------------------------------------------+
module baccarat_fsm
  import baccarat_pkg::*;
#(
  parameter int unsigned NATURAL_MIN     = 8,
  parameter int unsigned PLAYER_DRAW_MAX = 5
) (
  input  logic       slow_clock,
  input  logic       reset,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       player_win_light,
  output logic       dealer_win_light
);

  localparam logic [3:0] c_NATURAL_MIN     = 4'(NATURAL_MIN);
  localparam logic [3:0] c_PLAYER_DRAW_MAX = 4'(PLAYER_DRAW_MAX);

  state_t r_state;
  state_t w_next;
  logic   w_bank_draw;
  logic   w_natural;

  baccarat_bank_rule u_bank_rule (
    .dscore (dscore),
    .pcard3 (pcard3),
    .draw   (w_bank_draw)
  );

  assign w_natural = (pscore >= c_NATURAL_MIN) || (dscore >= c_NATURAL_MIN);

  always_ff @(posedge slow_clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next           = S_IDLE;
    load_pcard1      = 1'b0;
    load_pcard2      = 1'b0;
    load_pcard3      = 1'b0;
    load_dcard1      = 1'b0;
    load_dcard2      = 1'b0;
    load_dcard3      = 1'b0;
    player_win_light = 1'b0;
    dealer_win_light = 1'b0;
    case (r_state)
      S_IDLE: w_next = S_P1;
      S_P1: begin
        load_pcard1 = 1'b1;
        w_next      = S_D1;
      end
      S_D1: begin
        load_dcard1 = 1'b1;
        w_next      = S_P2;
      end
      S_P2: begin
        load_pcard2 = 1'b1;
        w_next      = S_D2;
      end
      S_D2: begin
        load_dcard2 = 1'b1;
        w_next      = S_EVAL;
      end
      S_EVAL: begin
        if (w_natural)                        w_next = S_DONE;
        else if (pscore <= c_PLAYER_DRAW_MAX) w_next = S_P3;
        else if (dscore <= c_PLAYER_DRAW_MAX) w_next = S_D3;
        else                                  w_next = S_DONE;
      end
      S_P3: begin
        load_pcard3 = 1'b1;
        w_next      = S_BANK;
      end
      // Player's third card is in its register by now, so pcard3 is valid.
      S_BANK: w_next = w_bank_draw ? S_D3 : S_DONE;
      S_D3: begin
        load_dcard3 = 1'b1;
        w_next      = S_DONE;
      end
      S_DONE: begin
        w_next           = S_DONE;
        player_win_light = (pscore >= dscore);
        dealer_win_light = (dscore >= pscore);
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_baccarat_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : tb_baccarat_fsm                                           |
// | Desc   : Scoreboard bench for the baccarat control FSM.            |
// | Rev    : 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_baccarat_fsm;

  logic       clk;
  logic       rst;
  logic [3:0] r_pscore, r_dscore, r_pcard3;
  logic       w_lp1, w_lp2, w_lp3, w_ld1, w_ld2, w_ld3, w_pwin, w_dwin;
  logic [7:0] w_obs;
  logic [7:0] r_sb[$];
  int         n_checks;
  int         n_fail;

  localparam logic [7:0] c_P1 = 8'h80;
  localparam logic [7:0] c_D1 = 8'h40;
  localparam logic [7:0] c_P2 = 8'h20;
  localparam logic [7:0] c_D2 = 8'h10;
  localparam logic [7:0] c_P3 = 8'h08;
  localparam logic [7:0] c_D3 = 8'h04;
  localparam logic [7:0] c_Z  = 8'h00;

  baccarat_fsm dut (
    .slow_clock       (clk),
    .reset            (rst),
    .pscore           (r_pscore),
    .dscore           (r_dscore),
    .pcard3           (r_pcard3),
    .load_pcard1      (w_lp1),
    .load_pcard2      (w_lp2),
    .load_pcard3      (w_lp3),
    .load_dcard1      (w_ld1),
    .load_dcard2      (w_ld2),
    .load_dcard3      (w_ld3),
    .player_win_light (w_pwin),
    .dealer_win_light (w_dwin)
  );

  assign w_obs = {w_lp1, w_ld1, w_lp2, w_ld2, w_lp3, w_ld3, w_pwin, w_dwin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %b expected %b (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference dealer rule written from the drawing table.
  function automatic logic ref_bank(input int ds, input int pc3);
    int pts;
    pts = (pc3 >= 1 && pc3 <= 9) ? pc3 : 0;
    if (ds <= 2) return 1'b1;
    if (ds == 3) return pts != 8;
    if (ds == 4) return pts inside {[2:7]};
    if (ds == 5) return pts inside {[4:7]};
    if (ds == 6) return pts inside {[6:7]};
    return 1'b0;
  endfunction

  function automatic logic [7:0] ref_lights(input int ps, input int ds);
    return {6'b0, ps >= ds, ds >= ps};
  endfunction

  task automatic push_game(input int ps, input int ds, input int pc3, input int n_done);
    r_sb.push_back(c_P1);
    r_sb.push_back(c_D1);
    r_sb.push_back(c_P2);
    r_sb.push_back(c_D2);
    r_sb.push_back(c_Z);
    if (!(ps >= 8 || ds >= 8)) begin
      if (ps <= 5) begin
        r_sb.push_back(c_P3);
        r_sb.push_back(c_Z);
        if (ref_bank(ds, pc3)) r_sb.push_back(c_D3);
      end else if (ds <= 5) begin
        r_sb.push_back(c_D3);
      end
    end
    for (int i = 0; i < n_done; i++) r_sb.push_back(ref_lights(ps, ds));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1 check_eq("reset_c1", w_obs, c_Z);
    @(posedge clk); #1 check_eq("reset_c2", w_obs, c_Z);
    rst = 1'b0;
  endtask

  // abort_at > 0 asserts reset after that many scoreboard entries.
  task automatic run_game(input string tag, input int ps, input int ds, input int pc3,
                          input int n_done, input int abort_at);
    int cyc;
    r_pscore = 4'(ps);
    r_dscore = 4'(ds);
    r_pcard3 = 4'(pc3);
    do_reset();
    push_game(ps, ds, pc3, n_done);
    cyc = 0;
    while (r_sb.size() > 0) begin
      logic [7:0] exp;
      @(posedge clk); #1;
      cyc++;
      exp = r_sb.pop_front();
      check_eq($sformatf("%s_c%0d", tag, cyc), w_obs, exp);
      if (abort_at > 0 && cyc == abort_at) begin
        rst = 1'b1;
        r_sb.delete();
        @(posedge clk); #1 check_eq({tag, "_abort"}, w_obs, c_Z);
        @(posedge clk); #1 check_eq({tag, "_abort_hold"}, w_obs, c_Z);
        rst = 1'b0;
      end
    end
  endtask

  task automatic change_done(input string tag, input int ps, input int ds, input int n);
    r_pscore = 4'(ps);
    r_dscore = 4'(ds);
    for (int i = 0; i < n; i++) r_sb.push_back(ref_lights(ps, ds));
    while (r_sb.size() > 0) begin
      logic [7:0] exp;
      @(posedge clk); #1;
      exp = r_sb.pop_front();
      check_eq(tag, w_obs, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    r_pscore = 4'd0;
    r_dscore = 4'd0;
    r_pcard3 = 4'd0;

    run_game("both_draw", 3, 2, 5, 2, 0);
    run_game("natural", 8, 4, 0, 2, 0);
    run_game("p_stands", 6, 5, 0, 1, 0);
    change_done("p_stands_dlight", 6, 7, 2);
    run_game("bank6_7", 4, 6, 7, 1, 0);
    run_game("bank6_Q", 4, 6, 12, 1, 0);
    run_game("bank3_8", 4, 3, 8, 1, 0);
    run_game("tie", 7, 7, 0, 10, 0);
    run_game("abort_p3", 3, 2, 5, 0, 6);
    run_game("restart", 3, 2, 5, 1, 0);
    run_game("illegal_pc3", 3, 2, 15, 1, 0);
    run_game("illegal_ds", 3, 12, 0, 2, 0);
    run_game("stand_both", 7, 6, 0, 1, 0);

    for (int ds = 0; ds < 8; ds++)
      for (int pc = 0; pc < 14; pc++)
        run_game($sformatf("sweep_d%0d_p%0d", ds, pc), 5, ds, pc, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
